in_service_control_8259a: RTL

Acknowledge-side sequencer and in-service register owner for the 8259A core. It consumes the one-hot `interrupt` produced by the priority resolver and tracks the CPU INTA# pulse sequence (2 pulses in 8086 mode, 3 in 8080 mode). It sets the in-service bit, clears the matching request, and processes EOI and rotation commands. It drives `in_service_register`, `highest_level_in_service` and `priority_rotate` back into the resolver.

---
 rtl/in_service_control_8259a.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/in_service_control_8259a.sv
// in_service_control_8259a
// Acknowledge-side sequencer and in-service register owner for the 8259A core.
// It follows the INTA# pulse train (2 pulses for 8086, 3 for 8080), sets the
// in-service bit and clears the matching request on the first pulse, and
// handles EOI, rotation and set-priority commands.
// Optional feature macro: IN_SERVICE_AUTO_EOI_EN enables automatic EOI
// (auto_eoi_config / rotate_on_aeoi); when undefined both inputs are ignored.
module in_service_control_8259a (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge_n,
    input  logic       mode_8086,
    input  logic       auto_eoi_config,
    input  logic       rotate_on_aeoi,
    input  logic       eoi_command,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       set_priority_command,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_interrupt_request,
    output logic [2:0] ack_level,
    output logic [1:0] ack_byte_index,
    output logic       end_of_acknowledge
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE1 = 3'd1,
        GAP1   = 3'd2,
        PULSE2 = 3'd3,
        GAP2   = 3'd4,
        PULSE3 = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       inta_q;
    logic       fall_event;
    logic       rise_event;
    logic       spurious_q;
    logic       spurious_d;
    logic [2:0] ack_level_d;
    logic [2:0] rotate_d;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;
    logic [7:0] isr_d;
    logic [7:0] clear_d;
    logic       eoa_d;
    logic       end_sequence;
    logic [2:0] irq_level;
    logic [2:0] highest_level;
    logic       highest_found;

`ifndef IN_SERVICE_AUTO_EOI_EN
    logic unused_aeoi_inputs;
    assign unused_aeoi_inputs = auto_eoi_config ^ rotate_on_aeoi;
`endif

    assign fall_event = inta_q & ~interrupt_acknowledge_n;
    assign rise_event = ~inta_q & interrupt_acknowledge_n;

    // Encode the one-hot resolved interrupt into a level number.
    always_comb begin
        irq_level = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (interrupt[i]) irq_level = 3'(i);
        end
    end

    // Scan the ISR from highest to lowest priority under the current rotation.
    always_comb begin
        logic [2:0] idx;
        highest_found            = 1'b0;
        highest_level            = 3'd0;
        highest_level_in_service = 8'h00;
        idx                      = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = priority_rotate + 3'(k);
            if (!highest_found && in_service_register[idx]) begin
                highest_found                 = 1'b1;
                highest_level                 = idx;
                highest_level_in_service[idx] = 1'b1;
            end
        end
    end

    // Pulse number reported to the data-bus side, derived from the state.
    always_comb begin
        case (state_q)
            PULSE1, GAP1: ack_byte_index = 2'd1;
            PULSE2, GAP2: ack_byte_index = 2'd2;
            PULSE3:       ack_byte_index = 2'd3;
            default:      ack_byte_index = 2'd0;
        endcase
    end

    // Next-state logic plus all ISR, rotation and pulse updates for this cycle.
    always_comb begin
        state_d      = state_q;
        spurious_d   = spurious_q;
        ack_level_d  = ack_level;
        rotate_d     = priority_rotate;
        isr_set      = 8'h00;
        isr_clr      = 8'h00;
        clear_d      = 8'h00;
        eoa_d        = 1'b0;
        end_sequence = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_event) begin
                    state_d = PULSE1;
                    if (interrupt != 8'h00) begin
                        ack_level_d = irq_level;
                        spurious_d  = 1'b0;
                        isr_set     = 8'h01 << irq_level;
                        clear_d     = 8'h01 << irq_level;
                    end else begin
                        ack_level_d = 3'd7;
                        spurious_d  = 1'b1;
                    end
                end
            end
            PULSE1: if (rise_event) state_d = GAP1;
            GAP1:   if (fall_event) state_d = PULSE2;
            PULSE2: begin
                if (rise_event) begin
                    if (mode_8086) begin
                        state_d      = IDLE;
                        end_sequence = 1'b1;
                    end else begin
                        state_d = GAP2;
                    end
                end
            end
            GAP2:   if (fall_event) state_d = PULSE3;
            PULSE3: begin
                if (rise_event) begin
                    state_d      = IDLE;
                    end_sequence = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_sequence) begin
            eoa_d = 1'b1;
`ifdef IN_SERVICE_AUTO_EOI_EN
            if (auto_eoi_config && !spurious_q) begin
                isr_clr[ack_level] = 1'b1;
                if (rotate_on_aeoi) rotate_d = ack_level;
            end
`endif
        end

        if (eoi_command) begin
            if (eoi_specific) begin
                isr_clr[eoi_level] = 1'b1;
                if (eoi_rotate) rotate_d = eoi_level;
            end else if (highest_found) begin
                isr_clr[highest_level] = 1'b1;
                if (eoi_rotate) rotate_d = highest_level;
            end
        end

        if (set_priority_command) rotate_d = eoi_level;

        isr_d = (in_service_register & ~isr_clr) | isr_set;
    end

    // State, INTA sample, ISR, rotation and one-cycle pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                 <= IDLE;
            inta_q                  <= 1'b1;
            spurious_q              <= 1'b0;
            in_service_register     <= 8'h00;
            priority_rotate         <= 3'b111;
            ack_level               <= 3'd7;
            clear_interrupt_request <= 8'h00;
            end_of_acknowledge      <= 1'b0;
        end else begin
            state_q                 <= state_d;
            inta_q                  <= interrupt_acknowledge_n;
            spurious_q              <= spurious_d;
            in_service_register     <= isr_d;
            priority_rotate         <= rotate_d;
            ack_level               <= ack_level_d;
            clear_interrupt_request <= clear_d;
            end_of_acknowledge      <= eoa_d;
        end
    end

endmodule
